// File: rtl/ym_pcm_rate_bridge_pkg.sv
// Shared definitions for the YM3016 -> S/PDIF rate bridge: FSM encodings,
// register map, CTRL/STATUS field positions and a saturating counter helper.
package ym_pcm_rate_bridge_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1
  } state_e;

  localparam logic ADDR_STATUS = 1'b0;
  localparam logic ADDR_CTRL   = 1'b1;

  localparam int STATUS_UND_LSB   = 0;
  localparam int STATUS_OVF_LSB   = 8;
  localparam int STATUS_LEVEL_LSB = 16;
  localparam int STATUS_RUN_BIT   = 24;

  localparam int STATUS_CLR_UND_BIT = 0;
  localparam int STATUS_CLR_OVF_BIT = 1;

  // Packed so the field order lands on CTRL bits [4:2]=att, [1]=swap, [0]=mute.
  typedef struct packed {
    logic [2:0] att;
    logic       swap;
    logic       mute;
  } ctrl_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ym_pcm_rate_bridge_if.sv
// Bundles the PCM input, S/PDIF sample port and Wishbone slave signals of the
// rate bridge; master drives stimulus/bus requests, slave is the bridge.
interface ym_pcm_rate_bridge_if;

  logic        in_valid;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        spdif_channel;
  logic [23:0] spdif_pcm;
  logic        wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdata;
  logic        wb_ack;

  modport master (
    output in_valid, in_left, in_right, spdif_channel,
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  spdif_pcm, wb_rdata, wb_ack
  );

  modport slave (
    input  in_valid, in_left, in_right, spdif_channel,
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output spdif_pcm, wb_rdata, wb_ack
  );

endinterface

// File: rtl/ym_pcm_rate_bridge_fifo.sv
// Synchronous stereo-frame FIFO with asynchronous read port, fill level, and
// simultaneous push/pop (a pop frees the slot a same-cycle push needs when full).
module ym_pcm_rate_bridge_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [AW:0] LP_DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_level == LP_DEPTH);
  assign o_empty   = (r_level == {(AW+1){1'b0}});
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Storage array, left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {(AW+1){1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ym_pcm_rate_bridge.sv
// Rate bridge between the YM3016 decoder and spdif_tx: buffers stereo frames,
// pops one per S/PDIF frame, repeats on underrun, drops on overflow; WB status/ctrl.
module ym_pcm_rate_bridge
  import ym_pcm_rate_bridge_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int PREFILL = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ym_pcm_rate_bridge_if.slave   bus
);

  localparam logic [FIFO_AW:0] LP_PREFILL = (FIFO_AW+1)'(PREFILL);

  state_e              r_state;
  logic                r_ch_q;
  logic signed [15:0]  r_held_l;
  logic signed [15:0]  r_held_r;
  logic [7:0]          r_und_cnt;
  logic [7:0]          r_ovf_cnt;
  ctrl_t               r_ctrl;
  logic                r_wb_ack;
  logic [31:0]         r_wb_rdata;

  logic                w_strobe;
  logic                w_pop;
  logic                w_ovf_evt;
  logic                w_und_evt;
  logic                w_wb_wr;
  logic                w_clr_und;
  logic                w_clr_ovf;
  logic [31:0]         w_fifo_rdata;
  logic [FIFO_AW:0]    w_level;
  logic                w_full;
  logic                w_empty;
  logic [31:0]         w_status;
  logic                w_sel;
  logic signed [15:0]  w_s;
  logic signed [15:0]  w_s_att;
  logic [23:0]         w_pcm;

  // A frame starts when spdif_tx moves from the right slot back to the left.
  assign w_strobe  = r_ch_q & ~bus.spdif_channel;
  assign w_pop     = w_strobe & (r_state == ST_RUN) & ~w_empty;
  assign w_und_evt = w_strobe & (r_state == ST_RUN) & w_empty;
  assign w_ovf_evt = bus.in_valid & w_full & ~w_pop;

  assign w_wb_wr   = bus.wb_cyc & bus.wb_we & r_wb_ack;
  assign w_clr_und = w_wb_wr & (bus.wb_addr == ADDR_STATUS) & bus.wb_wdata[STATUS_CLR_UND_BIT];
  assign w_clr_ovf = w_wb_wr & (bus.wb_addr == ADDR_STATUS) & bus.wb_wdata[STATUS_CLR_OVF_BIT];

  ym_pcm_rate_bridge_fifo #(
    .AW (FIFO_AW),
    .DW (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.in_valid),
    .i_wdata ({bus.in_left, bus.in_right}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Registered copy of the channel select for frame-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch_q <= 1'b0;
    end else begin
      r_ch_q <= bus.spdif_channel;
    end
  end

  // Fill/run state machine owning the held output frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_FILL;
      r_held_l <= 16'sd0;
      r_held_r <= 16'sd0;
    end else begin
      case (r_state)
        ST_FILL: begin
          r_held_l <= 16'sd0;
          r_held_r <= 16'sd0;
          if (w_level >= LP_PREFILL) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_pop) begin
            r_held_l <= w_fifo_rdata[31:16];
            r_held_r <= w_fifo_rdata[15:0];
          end else if (w_und_evt) begin
            r_state <= ST_FILL;
          end
        end
        default: begin
          r_state  <= ST_FILL;
          r_held_l <= 16'sd0;
          r_held_r <= 16'sd0;
        end
      endcase
    end
  end

  // Saturating event counters; a software clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_und_cnt <= 8'd0;
      r_ovf_cnt <= 8'd0;
    end else begin
      if (w_clr_und) begin
        r_und_cnt <= 8'd0;
      end else if (w_und_evt) begin
        r_und_cnt <= sat_inc8(r_und_cnt);
      end
      if (w_clr_ovf) begin
        r_ovf_cnt <= 8'd0;
      end else if (w_ovf_evt) begin
        r_ovf_cnt <= sat_inc8(r_ovf_cnt);
      end
    end
  end

  // STATUS register image.
  always_comb begin
    w_status = 32'h0000_0000;
    w_status[STATUS_UND_LSB +: 8]            = r_und_cnt;
    w_status[STATUS_OVF_LSB +: 8]            = r_ovf_cnt;
    w_status[STATUS_LEVEL_LSB +: FIFO_AW+1]  = w_level;
    w_status[STATUS_RUN_BIT]                 = (r_state == ST_RUN);
  end

  // Wishbone slave: single-pulse ack, read data only alongside ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_ack   <= 1'b0;
      r_wb_rdata <= 32'h0000_0000;
      r_ctrl     <= '{att: 3'd0, swap: 1'b0, mute: 1'b0};
    end else begin
      r_wb_ack <= bus.wb_cyc & ~r_wb_ack;
      if (bus.wb_cyc & ~r_wb_ack) begin
        r_wb_rdata <= (bus.wb_addr == ADDR_CTRL) ? {27'd0, r_ctrl} : w_status;
      end else begin
        r_wb_rdata <= 32'h0000_0000;
      end
      if (w_wb_wr & (bus.wb_addr == ADDR_CTRL)) begin
        r_ctrl <= ctrl_t'(bus.wb_wdata[4:0]);
      end
    end
  end

  // Zero-latency sample path so spdif_tx sees the right slot immediately.
  always_comb begin
    w_sel   = r_ctrl.swap ^ bus.spdif_channel;
    w_s     = w_sel ? r_held_r : r_held_l;
    w_s_att = w_s >>> r_ctrl.att;
    if (r_ctrl.mute) begin
      w_pcm = 24'h00_0000;
    end else begin
      w_pcm = {w_s_att, 8'h00};
    end
  end

  assign bus.spdif_pcm = w_pcm;
  assign bus.wb_ack    = r_wb_ack;
  assign bus.wb_rdata  = r_wb_rdata;

endmodule

// File: tb/tb_ym_pcm_rate_bridge.sv
// Directed self-checking bench for ym_pcm_rate_bridge: fill/run, overflow,
// underrun, output controls, full push+pop, and a long rate-mismatch stream.
module tb_ym_pcm_rate_bridge;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  ym_pcm_rate_bridge_if bus ();

  ym_pcm_rate_bridge #(
    .FIFO_AW (4),
    .PREFILL (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.in_left       = 16'h0000;
    bus.in_right      = 16'h0000;
    bus.spdif_channel = 1'b0;
    bus.wb_addr       = 1'b0;
    bus.wb_wdata      = 32'h0;
    bus.wb_we         = 1'b0;
    bus.wb_cyc        = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    bus.in_valid = 1'b1;
    bus.in_left  = l;
    bus.in_right = r;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic frame_strobe();
    bus.spdif_channel = 1'b1;
    tick();
    bus.spdif_channel = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic a, output logic [31:0] d);
    bus.wb_addr = a;
    bus.wb_we   = 1'b0;
    bus.wb_cyc  = 1'b1;
    tick();
    d = bus.wb_rdata;
    bus.wb_cyc = 1'b0;
    tick();
  endtask

  task automatic wb_write(input logic a, input logic [31:0] d);
    bus.wb_addr  = a;
    bus.wb_wdata = d;
    bus.wb_we    = 1'b1;
    bus.wb_cyc   = 1'b1;
    tick();
    tick();
    bus.wb_cyc = 1'b0;
    bus.wb_we  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.wb_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %0b expected 0", bus.wb_ack); end
    total++; if (bus.wb_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", bus.wb_rdata); end
    total++; if (bus.spdif_pcm !== 24'h0) begin bad++; $display("FAIL reset_pcm: got %h expected 0", bus.spdif_pcm); end
    bus.wb_addr = 1'b0;
    bus.wb_cyc  = 1'b1;
    tick();
    total++; if (bus.wb_ack !== 1'b1) begin bad++; $display("FAIL reset_ack_pulse: got %0b expected 1", bus.wb_ack); end
    total++; if (bus.wb_rdata !== 32'h0) begin bad++; $display("FAIL reset_status: got %h expected 0", bus.wb_rdata); end
    bus.wb_cyc = 1'b0;
    tick();
    total++; if (bus.wb_ack !== 1'b0) begin bad++; $display("FAIL reset_ack_drop: got %0b expected 0", bus.wb_ack); end
    total++; if (bus.wb_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata_idle: got %h expected 0", bus.wb_rdata); end
  endtask

  task automatic test_fill_run();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) push(16'h1234, 16'hABCD);
    tick();
    wb_read(1'b0, d);
    total++; if (d !== 32'h0108_0000) begin bad++; $display("FAIL fill_status: got %h expected 01080000", d); end
    total++; if (bus.spdif_pcm !== 24'h0) begin bad++; $display("FAIL fill_pcm_pre: got %h expected 0", bus.spdif_pcm); end
    frame_strobe();
    total++; if (bus.spdif_pcm !== 24'h123400) begin bad++; $display("FAIL run_pcm_left: got %h expected 123400", bus.spdif_pcm); end
    bus.spdif_channel = 1'b1;
    #1;
    total++; if (bus.spdif_pcm !== 24'hABCD00) begin bad++; $display("FAIL run_pcm_right: got %h expected abcd00", bus.spdif_pcm); end
    bus.spdif_channel = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 20; i++) push(16'h0100, 16'h0200);
    wb_read(1'b0, d);
    total++; if (d !== 32'h0110_0400) begin bad++; $display("FAIL ovf_status: got %h expected 01100400", d); end
    wb_write(1'b0, 32'h0000_0002);
    wb_read(1'b0, d);
    total++; if (d !== 32'h0110_0000) begin bad++; $display("FAIL ovf_clear: got %h expected 01100000", d); end
  endtask

  task automatic test_underrun();
    logic [31:0] d;
    logic [15:0] l;
    logic [15:0] r;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      l = 16'h0100 + 16'(i);
      r = 16'h0200 + 16'(i);
      push(l, r);
    end
    tick();
    frame_strobe();
    total++; if (bus.spdif_pcm !== 24'h010000) begin bad++; $display("FAIL und_first_pop: got %h expected 010000", bus.spdif_pcm); end
    for (int i = 0; i < 6; i++) frame_strobe();
    frame_strobe();
    total++; if (bus.spdif_pcm !== 24'h010700) begin bad++; $display("FAIL und_last_pop: got %h expected 010700", bus.spdif_pcm); end
    frame_strobe();
    total++; if (bus.spdif_pcm !== 24'h010700) begin bad++; $display("FAIL und_hold: got %h expected 010700", bus.spdif_pcm); end
    tick();
    total++; if (bus.spdif_pcm !== 24'h0) begin bad++; $display("FAIL und_cleared: got %h expected 0", bus.spdif_pcm); end
    wb_read(1'b0, d);
    total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL und_status: got %h expected 00000001", d); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) push(16'h8000, 16'h4321);
    tick();
    frame_strobe();
    total++; if (bus.spdif_pcm !== 24'h800000) begin bad++; $display("FAIL ctrl_plain: got %h expected 800000", bus.spdif_pcm); end
    wb_write(1'b1, 32'h0000_0010);
    total++; if (bus.spdif_pcm !== 24'hF80000) begin bad++; $display("FAIL ctrl_att4: got %h expected f80000", bus.spdif_pcm); end
    wb_read(1'b1, d);
    total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL ctrl_readback: got %h expected 00000010", d); end
    wb_write(1'b1, 32'h0000_0011);
    total++; if (bus.spdif_pcm !== 24'h0) begin bad++; $display("FAIL ctrl_mute: got %h expected 0", bus.spdif_pcm); end
    wb_write(1'b1, 32'h0000_0002);
    total++; if (bus.spdif_pcm !== 24'h432100) begin bad++; $display("FAIL ctrl_swap_ch0: got %h expected 432100", bus.spdif_pcm); end
    bus.spdif_channel = 1'b1;
    #1;
    total++; if (bus.spdif_pcm !== 24'h800000) begin bad++; $display("FAIL ctrl_swap_ch1: got %h expected 800000", bus.spdif_pcm); end
    bus.spdif_channel = 1'b0;
    wb_write(1'b1, 32'h0000_001C);
    bus.spdif_channel = 1'b1;
    #1;
    total++; if (bus.spdif_pcm !== 24'h008600) begin bad++; $display("FAIL ctrl_att7: got %h expected 008600", bus.spdif_pcm); end
    bus.spdif_channel = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    logic [15:0] l;
    logic [15:0] r;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      l = 16'h1000 + 16'(i);
      r = 16'h2000 + 16'(i);
      push(l, r);
    end
    tick();
    wb_read(1'b0, d);
    total++; if (d !== 32'h0110_0000) begin bad++; $display("FAIL full_status: got %h expected 01100000", d); end
    bus.spdif_channel = 1'b1;
    tick();
    bus.spdif_channel = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_left  = 16'h7777;
    bus.in_right = 16'h8888;
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.spdif_pcm !== 24'h100000) begin bad++; $display("FAIL full_pop_oldest: got %h expected 100000", bus.spdif_pcm); end
    bus.spdif_channel = 1'b1;
    #1;
    total++; if (bus.spdif_pcm !== 24'h200000) begin bad++; $display("FAIL full_pop_right: got %h expected 200000", bus.spdif_pcm); end
    bus.spdif_channel = 1'b0;
    wb_read(1'b0, d);
    total++; if (d !== 32'h0110_0000) begin bad++; $display("FAIL full_pushpop_status: got %h expected 01100000", d); end
    push(16'h5555, 16'h6666);
    wb_read(1'b0, d);
    total++; if (d !== 32'h0110_0100) begin bad++; $display("FAIL full_drop: got %h expected 01100100", d); end
  endtask

  task automatic test_stream_reset();
    logic [31:0] d;
    do_reset();
    wb_write(1'b1, 32'h0000_0002);
    for (int c = 0; c < 30000; c++) begin
      bus.in_valid      = ((c % 10) == 0);
      bus.in_left       = c[15:0];
      bus.in_right      = ~c[15:0];
      bus.spdif_channel = ((c % 12) < 6);
      tick();
    end
    bus.in_valid      = 1'b0;
    bus.spdif_channel = 1'b0;
    wb_read(1'b0, d);
    total++; if ((d & 32'h0100_FFFF) !== 32'h0100_FF00) begin bad++; $display("FAIL stream_counts: got %h expected 0100ff00 under mask 0100ffff", d); end
    for (int c = 0; c < 100; c++) begin
      bus.in_valid      = ((c % 10) == 0);
      bus.spdif_channel = ((c % 12) < 6);
      tick();
    end
    bus.in_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    total++; if (bus.spdif_pcm !== 24'h0) begin bad++; $display("FAIL mid_reset_pcm_l: got %h expected 0", bus.spdif_pcm); end
    bus.spdif_channel = 1'b1;
    #1;
    total++; if (bus.spdif_pcm !== 24'h0) begin bad++; $display("FAIL mid_reset_pcm_r: got %h expected 0", bus.spdif_pcm); end
    bus.spdif_channel = 1'b0;
    total++; if (bus.wb_ack !== 1'b0) begin bad++; $display("FAIL mid_reset_ack: got %0b expected 0", bus.wb_ack); end
    wb_read(1'b0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_status: got %h expected 0", d); end
    wb_read(1'b1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_ctrl: got %h expected 0", d); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b1;
    test_reset();
    test_fill_run();
    test_overflow();
    test_underrun();
    test_ctrl();
    test_full_push_pop();
    test_stream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
